smg_scan_capture: RTL and testbench
===================================

# smg_scan_capture

Receive-side counterpart of the six-digit seven-segment scan driver. Monitors the one-cold digit-select bus and the segment bus, waits for each scan slot to settle, decodes the active-low segment code back into a hex nibble plus decimal point, and stores it per digit. Instantiated in loopback/self-check builds and on the test bench to confirm what the display actually shows, with frame-complete and error strobes.

## Interface
Parameters:
- SETTLE, 16'd15: input-unchanged cycles required after the first sample before a slot is captured.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RSTn  in  1  reset, synchronous, active-low.
- Scan_Sig  in  6  digit select, active-low one-cold; 6'b011_111 = digit 0 … 6'b111_110 = digit 5.
- Seg_Sig  in  8  segment code, active-low; [7]=dp, [6:0]=g..a.
- Digit_Data  out  24  captured nibbles, digit n at [4n+3:4n].
- Dp_Data  out  6  captured decimal points, 1 = lit; bit n = digit n.
- Digit_Valid  out  6  bit n set once digit n captured with a legal code since reset.
- Frame_Done  out  1  one-cycle pulse: digits 0..5 captured in order.
- Order_Err  out  1  one-cycle pulse: digit captured out of sequence.
- Code_Err  out  1  one-cycle pulse: captured Seg_Sig[6:0] not a hex glyph.

## Operation
- Input register: Scan_Sig/Seg_Sig sampled every edge into prev regs (same clock domain, no synchroniser).
- Legal scan: exactly one bit of Scan_Sig low. All-ones, 6'b100_000 or multiple lows are illegal: counter held at 0, state IDLE, no strobes.
- FSM states: IDLE (pattern illegal or changed) -> SETTLE (counting) -> HELD (captured, waiting for change).
  - IDLE -> SETTLE when inputs legal; count = 0.
  - SETTLE: count increments each edge inputs equal prev; any change -> count = 0, stay SETTLE (or IDLE if illegal).
  - SETTLE -> HELD on the capture edge (count == SETTLE and inputs unchanged).
  - HELD -> SETTLE (count 0) on any input change; no re-capture while HELD.
- Decode [6:0] active-low: C0 0, F9 1, A4 2, B0 3, 99 4, 92 5, 82 6, F8 7, 80 8, 90 9, 88 A, 83 B, C6 C, A1 D, 86 E, 8E F (values listed with bit 7 = 1).
- Capture of digit n with legal glyph: Digit_Data nibble n, Dp_Data[n] = ~Seg_Sig[7], Digit_Valid[n] = 1.
- Illegal glyph: Code_Err pulses, nibble/dp/valid for n unchanged; sequence still advances per order rule.
- Order tracker exp (0..5): capture with n == exp -> exp = exp+1 (5 wraps to 0, Frame_Done pulses if no Code_Err since last digit 0 capture). n != exp -> Order_Err pulses, exp = n+1 (mod 6) if n == 0 else exp = 0.
- Code_Err and Order_Err may pulse on the same edge; Frame_Done suppressed on that edge.

## Timing
- Reset (RSTn low at an edge): Digit_Data 0, Dp_Data 0, Digit_Valid 0, all strobes 0, count 0, exp 0, state IDLE; reset mid-slot discards partial count.
- A pattern first present at edge k is captured at edge k+SETTLE+1 (held ≥ SETTLE+2 cycles incl. edge k); outputs and strobes visible after that edge, strobes high for exactly that one cycle.
- Pattern held SETTLE+1 cycles or fewer: not captured.
- Driver at 1 ms/slot, 50 MHz: one capture per slot, Frame_Done every 6 ms.
- Counter saturates in HELD; no wrap-induced re-capture.

## Test plan
- Reset, then drive digits 0..5 with C0,F9,A4,B0,99,12 each 40 cycles -> Digit_Data 24'h543210, Dp_Data 6'b100000, Digit_Valid 6'h3F, one Frame_Done after digit 5.
- Digit 2 pattern held 16 vs 17 cycles (SETTLE=15) -> no capture at 16; capture on 17th edge.
- Sequence 0,1,3 -> Order_Err on digit 3 capture, exp becomes 0; then 0..5 -> Frame_Done.
- Digit 4 with Seg_Sig FF -> Code_Err pulse, nibble 4 unchanged, no Frame_Done that frame.
- Scan_Sig 6'b100_000 or 6'b001_111 for 100 cycles -> no strobes, outputs unchanged.
- RSTn low one cycle mid-frame after digits 0..2 -> all outputs 0, next 0..5 frame gives Frame_Done.

Source files
------------

// File: rtl/smg_scan_capture.sv
// Receive-side monitor for a six-digit multiplexed seven-segment display.
// Waits for each scan slot to settle, decodes the segment glyph and keeps a per-digit copy.
module smg_scan_capture #(
  parameter logic [15:0] SETTLE = 16'd15
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [5:0]  Scan_Sig,
  input  logic [7:0]  Seg_Sig,
  output logic [23:0] Digit_Data,
  output logic [5:0]  Dp_Data,
  output logic [5:0]  Digit_Valid,
  output logic        Frame_Done,
  output logic        Order_Err,
  output logic        Code_Err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HELD
  } state_e;

  // Returns {legal, nibble} for an active-low g..a glyph.
  function automatic logic [4:0] decode_glyph(input logic [6:0] code);
    logic [4:0] r;
    case (code)
      7'h40:   r = {1'b1, 4'h0};
      7'h79:   r = {1'b1, 4'h1};
      7'h24:   r = {1'b1, 4'h2};
      7'h30:   r = {1'b1, 4'h3};
      7'h19:   r = {1'b1, 4'h4};
      7'h12:   r = {1'b1, 4'h5};
      7'h02:   r = {1'b1, 4'h6};
      7'h78:   r = {1'b1, 4'h7};
      7'h00:   r = {1'b1, 4'h8};
      7'h10:   r = {1'b1, 4'h9};
      7'h08:   r = {1'b1, 4'hA};
      7'h03:   r = {1'b1, 4'hB};
      7'h46:   r = {1'b1, 4'hC};
      7'h21:   r = {1'b1, 4'hD};
      7'h06:   r = {1'b1, 4'hE};
      7'h0E:   r = {1'b1, 4'hF};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [5:0]  scan_prev_q, scan_prev_d;
  logic [7:0]  seg_prev_q, seg_prev_d;
  logic [2:0]  exp_q, exp_d;
  logic        frame_bad_q, frame_bad_d;
  logic [23:0] digit_q, digit_d;
  logic [5:0]  dp_q, dp_d;
  logic [5:0]  valid_q, valid_d;
  logic        frame_done_q, frame_done_d;
  logic        order_err_q, order_err_d;
  logic        code_err_q, code_err_d;

  logic        scan_legal;
  logic [2:0]  low_count;
  logic [2:0]  digit_idx;
  logic        inputs_same;
  logic        capture;
  logic [4:0]  glyph;
  logic        glyph_ok;
  logic [3:0]  glyph_nib;

  // Digit n is selected by Scan_Sig bit (5-n) going low.
  always_comb begin
    low_count = 3'd0;
    digit_idx = 3'd0;
    for (int i = 0; i < 6; i++) begin
      low_count = low_count + {2'b00, ~Scan_Sig[i]};
      if (!Scan_Sig[5-i]) digit_idx = 3'(i);
    end
    scan_legal  = (low_count == 3'd1);
    inputs_same = (Scan_Sig == scan_prev_q) && (Seg_Sig == seg_prev_q);
    glyph       = decode_glyph(Seg_Sig[6:0]);
    glyph_ok    = glyph[4];
    glyph_nib   = glyph[3:0];
  end

  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    cnt_d        = cnt_q;
    scan_prev_d  = Scan_Sig;
    seg_prev_d   = Seg_Sig;
    exp_d        = exp_q;
    frame_bad_d  = frame_bad_q;
    digit_d      = digit_q;
    dp_d         = dp_q;
    valid_d      = valid_q;
    frame_done_d = 1'b0;
    order_err_d  = 1'b0;
    code_err_d   = 1'b0;
    capture      = 1'b0;

    if (!scan_legal) begin
      state_d = ST_IDLE;
      cnt_d   = 16'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SETTLE;
          cnt_d   = 16'd0;
        end
        ST_SETTLE: begin
          if (!inputs_same) begin
            cnt_d = 16'd0;
          end else if (cnt_q == SETTLE) begin
            capture = 1'b1;
            state_d = ST_HELD;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        ST_HELD: begin
          // Count stays saturated at SETTLE until the slot changes.
          if (!inputs_same) begin
            state_d = ST_SETTLE;
            cnt_d   = 16'd0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 16'd0;
        end
      endcase
    end

    if (capture) begin
      if (glyph_ok) begin
        for (int i = 0; i < 6; i++) begin
          if (digit_idx == 3'(i)) begin
            digit_d[i*4 +: 4] = glyph_nib;
            dp_d[i]           = ~Seg_Sig[7];
            valid_d[i]        = 1'b1;
          end
        end
      end else begin
        code_err_d = 1'b1;
      end

      // A frame is clean only if no bad glyph was seen since the last digit-0 capture.
      if (digit_idx == 3'd0) frame_bad_d = ~glyph_ok;
      else                   frame_bad_d = frame_bad_q | ~glyph_ok;

      if (digit_idx == exp_q) begin
        if (exp_q == 3'd5) begin
          exp_d        = 3'd0;
          frame_done_d = ~frame_bad_q & glyph_ok;
        end else begin
          exp_d = exp_q + 3'd1;
        end
      end else begin
        order_err_d = 1'b1;
        exp_d       = (digit_idx == 3'd0) ? 3'd1 : 3'd0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of statement order.
    if (!RSTn) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 16'd0;
      scan_prev_q  <= 6'h3F;
      seg_prev_q   <= 8'hFF;
      exp_q        <= 3'd0;
      frame_bad_q  <= 1'b0;
      digit_q      <= 24'd0;
      dp_q         <= 6'd0;
      valid_q      <= 6'd0;
      frame_done_q <= 1'b0;
      order_err_q  <= 1'b0;
      code_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      scan_prev_q  <= scan_prev_d;
      seg_prev_q   <= seg_prev_d;
      exp_q        <= exp_d;
      frame_bad_q  <= frame_bad_d;
      digit_q      <= digit_d;
      dp_q         <= dp_d;
      valid_q      <= valid_d;
      frame_done_q <= frame_done_d;
      order_err_q  <= order_err_d;
      code_err_q   <= code_err_d;
    end
  end

  assign Digit_Data  = digit_q;
  assign Dp_Data     = dp_q;
  assign Digit_Valid = valid_q;
  assign Frame_Done  = frame_done_q;
  assign Order_Err   = order_err_q;
  assign Code_Err    = code_err_q;

endmodule

// File: tb/tb_smg_scan_capture.sv
// Self-checking bench for smg_scan_capture: directed scenarios plus random slots,
// compared every cycle against a run-length based reference model.
module tb_smg_scan_capture;

  localparam logic [15:0] SETTLE  = 16'd15;
  localparam int          CAP_RUN = int'(SETTLE) + 2;

  logic        clk  = 1'b0;
  logic        rstn = 1'b0;
  logic [5:0]  scan = 6'h3F;
  logic [7:0]  seg  = 8'hFF;
  logic [23:0] Digit_Data;
  logic [5:0]  Dp_Data;
  logic [5:0]  Digit_Valid;
  logic        Frame_Done;
  logic        Order_Err;
  logic        Code_Err;

  always #5 clk = ~clk;

  smg_scan_capture #(.SETTLE(SETTLE)) u_dut (
    .CLK        (clk),
    .RSTn       (rstn),
    .Scan_Sig   (scan),
    .Seg_Sig    (seg),
    .Digit_Data (Digit_Data),
    .Dp_Data    (Dp_Data),
    .Digit_Valid(Digit_Valid),
    .Frame_Done (Frame_Done),
    .Order_Err  (Order_Err),
    .Code_Err   (Code_Err)
  );

  logic [7:0] glyph [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: length of the current unbroken legal run decides capture.
  int         run_len = 0;
  logic [5:0] m_scan;
  logic [7:0] m_seg;
  logic [3:0] m_nib [6];
  logic       m_dp  [6];
  logic       m_val [6];
  int         m_exp   = 0;
  bit         m_clean = 1'b1;
  bit         m_fd, m_oe, m_ce;

  int n_fd = 0, n_oe = 0, n_ce = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, expv, $time);
    end
  endtask

  function automatic logic [5:0] sel(input int n);
    logic [5:0] s;
    s = 6'h3F;
    s[5-n] = 1'b0;
    return s;
  endfunction

  task automatic model_capture();
    int n, g;
    n = -1;
    g = -1;
    for (int i = 0; i < 6; i++) if (!scan[5-i]) n = i;
    for (int v = 0; v < 16; v++) if (glyph[v][6:0] == seg[6:0]) g = v;
    if (g >= 0) begin
      m_nib[n] = 4'(g);
      m_dp[n]  = ~seg[7];
      m_val[n] = 1'b1;
    end else begin
      m_ce = 1'b1;
    end
    if (n == 0)      m_clean = (g >= 0);
    else if (g < 0)  m_clean = 1'b0;
    if (n == m_exp) begin
      if (n == 5) begin
        m_exp = 0;
        m_fd  = m_clean;
      end else begin
        m_exp = m_exp + 1;
      end
    end else begin
      m_oe  = 1'b1;
      m_exp = (n == 0) ? 1 : 0;
    end
  endtask

  task automatic model_edge();
    m_fd = 1'b0;
    m_oe = 1'b0;
    m_ce = 1'b0;
    if (!rstn) begin
      for (int i = 0; i < 6; i++) begin
        m_nib[i] = 4'd0;
        m_dp[i]  = 1'b0;
        m_val[i] = 1'b0;
      end
      m_exp   = 0;
      m_clean = 1'b1;
      run_len = 0;
    end else begin
      if ($countones(~scan) != 1)                                  run_len = 0;
      else if (run_len > 0 && scan == m_scan && seg == m_seg) begin
        if (run_len <= CAP_RUN) run_len++;
      end else                                                      run_len = 1;
      if (run_len == CAP_RUN) model_capture();
    end
    m_scan = scan;
    m_seg  = seg;
  endtask

  task automatic cycle();
    logic [23:0] e_dig;
    logic [5:0]  e_dp, e_val;
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 6; i++) begin
      e_dig[i*4 +: 4] = m_nib[i];
      e_dp[i]         = m_dp[i];
      e_val[i]        = m_val[i];
    end
    check("digit_data", 32'(Digit_Data), 32'(e_dig));
    check("dp_data", 32'(Dp_Data), 32'(e_dp));
    check("digit_valid", 32'(Digit_Valid), 32'(e_val));
    check("frame_done", 32'(Frame_Done), 32'(m_fd));
    check("order_err", 32'(Order_Err), 32'(m_oe));
    check("code_err", 32'(Code_Err), 32'(m_ce));
    n_fd += int'(Frame_Done);
    n_oe += int'(Order_Err);
    n_ce += int'(Code_Err);
  endtask

  task automatic hold(input logic [5:0] s, input logic [7:0] g, input int len);
    scan = s;
    seg  = g;
    repeat (len) cycle();
  endtask

  // Digits first..last with their own glyph; dp_mask bit n lights dp of digit n; bad digit shows FF.
  task automatic run_digits(input int first, input int last, input int len,
                            input logic [5:0] dp_mask, input int bad);
    logic [7:0] code;
    for (int n = first; n <= last; n++) begin
      code = glyph[n];
      if (dp_mask[n]) code[7] = 1'b0;
      if (n == bad) code = 8'hFF;
      hold(sel(n), code, len);
    end
  endtask

  task automatic clear_counts();
    n_fd = 0;
    n_oe = 0;
    n_ce = 0;
  endtask

  initial begin
    logic [23:0] snap_dig;
    logic [5:0]  snap_dp, snap_val;
    logic [3:0]  snap_nib;
    logic [7:0]  code;
    int          n, len;

    rstn = 1'b0;
    scan = 6'h3F;
    seg  = 8'hFF;
    repeat (2) cycle();
    check("rst_digit_data", 32'(Digit_Data), 32'd0);
    check("rst_valid", 32'(Digit_Valid), 32'd0);
    check("rst_strobes", 32'({Frame_Done, Order_Err, Code_Err}), 32'd0);
    rstn = 1'b1;

    // Basic frame: C0,F9,A4,B0,99,12.
    clear_counts();
    run_digits(0, 5, 40, 6'b100000, -1);
    check("frame1_digits", 32'(Digit_Data), 32'h543210);
    check("frame1_dp", 32'(Dp_Data), 32'b100000);
    check("frame1_valid", 32'(Digit_Valid), 32'h3F);
    check("frame1_fd_count", 32'(n_fd), 32'd1);
    check("frame1_err_count", 32'(n_oe + n_ce), 32'd0);

    // Settle boundary: 16 edges is too short, 17 captures.
    hold(sel(2), 8'hF8, 16);
    check("settle16_nib2", 32'(Digit_Data[11:8]), 32'h2);
    hold(6'h3F, 8'hFF, 2);
    hold(sel(2), 8'hF8, 16);
    check("settle16b_nib2", 32'(Digit_Data[11:8]), 32'h2);
    hold(sel(2), 8'hF8, 1);
    check("settle17_nib2", 32'(Digit_Data[11:8]), 32'h7);
    hold(sel(2), 8'hF8, 30);

    // Order: 0,1,3 then a clean frame.
    clear_counts();
    run_digits(0, 1, 40, 6'b0, -1);
    hold(sel(3), glyph[3], 40);
    check("order_err_count", 32'(n_oe), 32'd1);
    clear_counts();
    run_digits(0, 5, 40, 6'b0, -1);
    check("order_recover_fd", 32'(n_fd), 32'd1);
    check("order_recover_oe", 32'(n_oe), 32'd0);

    // Bad glyph on digit 4.
    snap_nib = Digit_Data[19:16];
    clear_counts();
    run_digits(0, 5, 40, 6'b0, 4);
    check("code_err_count", 32'(n_ce), 32'd1);
    check("code_err_nib4", 32'(Digit_Data[19:16]), 32'(snap_nib));
    check("code_err_no_fd", 32'(n_fd), 32'd0);

    // Illegal scan patterns.
    snap_dig = Digit_Data;
    snap_dp  = Dp_Data;
    snap_val = Digit_Valid;
    clear_counts();
    hold(6'b100000, 8'hC0, 100);
    hold(6'b001111, 8'hF9, 100);
    check("illegal_strobes", 32'(n_fd + n_oe + n_ce), 32'd0);
    check("illegal_digits", 32'(Digit_Data), 32'(snap_dig));
    check("illegal_dp_valid", 32'({Dp_Data, Digit_Valid}), 32'({snap_dp, snap_val}));

    // Reset mid-frame.
    run_digits(0, 2, 40, 6'b000111, -1);
    hold(sel(3), glyph[3], 7);
    rstn = 1'b0;
    scan = 6'h3F;
    cycle();
    rstn = 1'b1;
    check("midrst_digits", 32'(Digit_Data), 32'd0);
    check("midrst_dp_valid", 32'({Dp_Data, Digit_Valid}), 32'd0);
    clear_counts();
    run_digits(0, 5, 40, 6'b010101, -1);
    check("midrst_fd", 32'(n_fd), 32'd1);
    check("midrst_valid", 32'(Digit_Valid), 32'h3F);

    // Random slots: mostly in order, near-threshold holds, some bad glyphs and illegal scans.
    for (int k = 0; k < 400; k++) begin
      n = ($urandom_range(0, 9) < 6) ? m_exp : int'($urandom_range(0, 5));
      if ($urandom_range(0, 9) < 8) begin
        code    = glyph[$urandom_range(0, 15)];
        code[7] = 1'($urandom_range(0, 1));
      end else begin
        code = 8'($urandom);
      end
      if ($urandom_range(0, 9) < 3) len = int'($urandom_range(CAP_RUN - 1, CAP_RUN));
      else                          len = int'($urandom_range(1, 40));
      if ($urandom_range(0, 19) == 0) hold(6'($urandom), code, len);
      else                            hold(sel(n), code, len);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
